// File: rtl/coef_mac_engine_if.sv
// Control/consumer bus of the coefficient MAC engine: coefficient load port,
// start/operand inputs and the registered result handshake.
interface coef_mac_engine_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ACC_W  = 32,
  parameter int AW     = $clog2(DEPTH)
);
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [DATA_W-1:0] coef_wdata;
  logic              start;
  logic [DATA_W-1:0] b_in;
  logic [AW:0]       count;
  logic              sgn;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  result;
  logic              overflow;

  modport master (
    output coef_we, coef_addr, coef_wdata, start, b_in, count, sgn,
    input  busy, done, result, overflow
  );

  modport slave (
    input  coef_we, coef_addr, coef_wdata, start, b_in, count, sgn,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/coef_mac_engine.sv
// Sequential multiply-accumulate: result = sum over L terms of coef[i]*B,
// signed or unsigned, with sticky overflow and a start/busy/done handshake.
module coef_mac_engine #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ACC_W  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst,
  coef_mac_engine_if.slave mac_if
);

  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_RUN   = 1'b1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);
  localparam logic [AW:0] ZERO_L  = (AW+1)'(0);

  if (ACC_W < 2*DATA_W) begin : g_acc_w_check
    $error("coef_mac_engine: ACC_W must be at least 2*DATA_W");
  end

  // Product of two DATA_W operands, extended to the accumulator width.
  // Extending both operands to 2*DATA_W first makes one multiplier serve both modes.
  function automatic logic [ACC_W-1:0] ext_prod(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic              s);
    logic [2*DATA_W-1:0] ea;
    logic [2*DATA_W-1:0] eb;
    logic [2*DATA_W-1:0] p;
    ea = {{DATA_W{a[DATA_W-1] & s}}, a};
    eb = {{DATA_W{b[DATA_W-1] & s}}, b};
    p  = ea * eb;
    if (s) begin
      return ACC_W'($signed(p));
    end else begin
      return ACC_W'(p);
    end
  endfunction

  function automatic logic add_ovf(input logic [ACC_W-1:0] x,
                                   input logic [ACC_W-1:0] y,
                                   input logic             s);
    logic [ACC_W:0] w;
    w = {1'b0, x} + {1'b0, y};
    if (s) begin
      return (x[ACC_W-1] == y[ACC_W-1]) && (w[ACC_W-1] != x[ACC_W-1]);
    end else begin
      return w[ACC_W];
    end
  endfunction

  logic [DATA_W-1:0] coef_q [DEPTH];
  logic [0:0]        state_q,    state_d;
  logic [ACC_W-1:0]  acc_q,      acc_d;
  logic [AW:0]       idx_q,      idx_d;
  logic [AW:0]       len_q,      len_d;
  logic [DATA_W-1:0] b_q,        b_d;
  logic              sgn_q,      sgn_d;
  logic              ovf_q,      ovf_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic [ACC_W-1:0]  result_q,   result_d;
  logic              overflow_q, overflow_d;

  logic              wr_en_s;
  logic [AW:0]       len_s;
  logic [AW:0]       idx_nxt_s;
  logic [ACC_W-1:0]  prod_s;
  logic [ACC_W-1:0]  sum_s;
  logic              add_ovf_s;

  assign wr_en_s   = mac_if.coef_we && (state_q == S_IDLE) && ({1'b0, mac_if.coef_addr} < DEPTH_L);
  assign len_s     = ((mac_if.count == ZERO_L) || (mac_if.count > DEPTH_L)) ? DEPTH_L : mac_if.count;
  assign idx_nxt_s = idx_q + ONE_L;
  assign prod_s    = ext_prod(coef_q[idx_q[AW-1:0]], b_q, sgn_q);
  assign sum_s     = acc_q + prod_s;
  assign add_ovf_s = add_ovf(acc_q, prod_s, sgn_q);

  // Next-state logic of the IDLE/RUN sequencer and its datapath registers.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    len_d      = len_q;
    b_d        = b_q;
    sgn_d      = sgn_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (mac_if.start) begin
          b_d     = mac_if.b_in;
          sgn_d   = mac_if.sgn;
          len_d   = len_s;
          acc_d   = {ACC_W{1'b0}};
          idx_d   = ZERO_L;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        acc_d = sum_s;
        ovf_d = ovf_q | add_ovf_s;
        idx_d = idx_nxt_s;
        if (idx_nxt_s == len_q) begin
          result_d   = sum_s;
          overflow_d = ovf_q | add_ovf_s;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          busy_d     = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= {ACC_W{1'b0}};
      idx_q      <= ZERO_L;
      len_q      <= DEPTH_L;
      b_q        <= {DATA_W{1'b0}};
      sgn_q      <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= {ACC_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      b_q        <= b_d;
      sgn_q      <= sgn_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  // Coefficient store; a same-cycle start sees the write from its first term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        coef_q[i] <= DATA_W'(i + 1);
      end
    end else if (wr_en_s) begin
      coef_q[mac_if.coef_addr] <= mac_if.coef_wdata;
    end
  end

  assign mac_if.busy     = busy_q;
  assign mac_if.done     = done_q;
  assign mac_if.result   = result_q;
  assign mac_if.overflow = overflow_q;

endmodule

// File: tb/tb_coef_mac_engine.sv
// Self-checking bench for coef_mac_engine: fixed vectors, hand-written
// corner sequences and randomized runs against an arithmetic reference model.
module tb_coef_mac_engine;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ACC_W  = 32;
  localparam int AW     = 3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [DATA_W-1:0] coef_m [DEPTH];

  coef_mac_engine_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W), .AW(AW)) bus ();

  coef_mac_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .mac_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] b;
    int          cnt;
    bit          s;
    logic [31:0] r;
    bit          ov;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) coef_m[i] = 16'(i + 1);
  endtask

  // True-arithmetic sum; overflow is any prefix sum outside the ACC_W range.
  function automatic void model(input logic [15:0] b, input int cnt, input bit s,
                                output logic [31:0] r, output bit ov, output int len);
    longint sum;
    longint av;
    longint bv;
    len = (cnt == 0 || cnt > DEPTH) ? DEPTH : cnt;
    sum = 0;
    ov  = 1'b0;
    bv  = s ? longint'($signed(b)) : longint'(b);
    for (int i = 0; i < len; i++) begin
      av  = s ? longint'($signed(coef_m[i])) : longint'(coef_m[i]);
      sum = sum + av * bv;
      if (s) begin
        if (sum > 64'sd2147483647 || sum < -64'sd2147483648) ov = 1'b1;
      end else begin
        if (sum > 64'sd4294967295) ov = 1'b1;
      end
    end
    r = sum[31:0];
  endfunction

  task automatic wr_coef(input int addr, input logic [15:0] data);
    @(negedge clk);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 3'(addr);
    bus.coef_wdata = data;
    @(negedge clk);
    bus.coef_we    = 1'b0;
    if (addr < DEPTH) coef_m[addr] = data;
  endtask

  task automatic start_run(input logic [15:0] b, input int cnt, input bit s);
    @(negedge clk);
    bus.start = 1'b1;
    bus.b_in  = b;
    bus.count = 4'(cnt);
    bus.sgn   = s;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_run(input string nm, input logic [31:0] r, input bit ov, input int len);
    int lat;
    chk({nm, ".busy"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk({nm, ".lat"}, 32'(lat), 32'(len));
    chk({nm, ".result"}, bus.result, r);
    chk({nm, ".ovf"}, 32'(bus.overflow), 32'(ov));
    @(negedge clk);
    chk({nm, ".pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic model_run(input string nm, input logic [15:0] b, input int cnt, input bit s);
    logic [31:0] r;
    bit          ov;
    int          len;
    model(b, cnt, s, r, ov, len);
    start_run(b, cnt, s);
    finish_run(nm, r, ov, len);
  endtask

  initial begin
    vec_t vecs [6];
    int   lat;
    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{16'h0001, 8, 1'b0, 32'h0000_0024, 1'b0, 8};
    vecs[1] = '{16'hFFFF, 8, 1'b0, 32'h0023_FFDC, 1'b0, 8};
    vecs[2] = '{16'hFFFF, 8, 1'b1, 32'hFFFF_FFDC, 1'b0, 8};
    vecs[3] = '{16'h0002, 3, 1'b0, 32'h0000_000C, 1'b0, 3};
    vecs[4] = '{16'h0001, 0, 1'b0, 32'h0000_0024, 1'b0, 8};
    vecs[5] = '{16'h0001, 9, 1'b0, 32'h0000_0024, 1'b0, 8};

    rst = 1'b1;
    bus.coef_we = 1'b0; bus.coef_addr = 3'd0; bus.coef_wdata = 16'd0;
    bus.start = 1'b0; bus.b_in = 16'd0; bus.count = 4'd0; bus.sgn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.ovf", 32'(bus.overflow), 32'd0);

    for (int i = 0; i < 6; i++) begin
      start_run(vecs[i].b, vecs[i].cnt, vecs[i].s);
      finish_run($sformatf("vec%0d", i), vecs[i].r, vecs[i].ov, vecs[i].lat);
    end

    for (int i = 0; i < DEPTH; i++) wr_coef(i, 16'hFFFF);
    start_run(16'hFFFF, 8, 1'b0);
    finish_run("allff", 32'hFFF0_0008, 1'b1, 8);
    start_run(16'h0000, 8, 1'b0);
    finish_run("zero_b", 32'h0000_0000, 1'b0, 8);

    // Reset three cycles into a run: outputs clear at once, table restored.
    start_run(16'h0001, 8, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.done", 32'(bus.done), 32'd0);
    chk("midrst.result", bus.result, 32'd0);
    chk("midrst.ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    start_run(16'h0001, 8, 1'b0);
    finish_run("after_rst", 32'd36, 1'b0, 8);

    // Start and coefficient write while busy are both dropped.
    start_run(16'h0001, 8, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.b_in = 16'd5; bus.count = 4'd2;
    bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_wdata = 16'h0100;
    @(negedge clk);
    bus.start = 1'b0; bus.coef_we = 1'b0;
    wait_done(lat);
    chk("busy_ign.lat", 32'(lat + 2), 32'd8);
    chk("busy_ign.result", bus.result, 32'd36);
    @(negedge clk);
    chk("busy_ign.idle", 32'(bus.busy), 32'd0);
    start_run(16'h0001, 8, 1'b0);
    finish_run("readback", 32'd36, 1'b0, 8);

    // Back-to-back: second start accepted in the done cycle.
    start_run(16'h0001, 3, 1'b0);
    wait_done(lat);
    chk("b2b.lat1", 32'(lat), 32'd3);
    chk("b2b.result1", bus.result, 32'd6);
    bus.start = 1'b1; bus.b_in = 16'd1; bus.count = 4'd4; bus.sgn = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    finish_run("b2b2", 32'd10, 1'b0, 4);

    // Start and write in the same idle cycle: the run sees the new value.
    @(negedge clk);
    bus.start = 1'b1; bus.b_in = 16'd1; bus.count = 4'd8; bus.sgn = 1'b0;
    bus.coef_we = 1'b1; bus.coef_addr = 3'd2; bus.coef_wdata = 16'd10;
    @(negedge clk);
    bus.start = 1'b0; bus.coef_we = 1'b0;
    coef_m[2] = 16'd10;
    finish_run("same_cyc", 32'd43, 1'b0, 8);

    for (int t = 0; t < 40; t++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) begin
        wr_coef(int'($urandom_range(0, DEPTH - 1)),
                ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      end
      model_run($sformatf("rnd%0d", t), 16'($urandom), int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/coef_mac_engine.md
# coef_mac_engine

Sequential multiply-accumulate engine that computes C = Σ A[i]·B over a programmable number of terms, where A is a writable on-chip coefficient store and B is a scalar sampled at start. It generalises the fixed 8-entry combinational dot-product in width, depth, term count and signedness, and adds a clocked start/busy/done handshake and overflow reporting. It sits between a control master that loads coefficients and a consumer that reads `result` on `done`.

## Interface
- `DATA_W`, 16: width of coefficients and of B.
- `DEPTH`, 8: number of coefficient entries, ≥2.
- `ACC_W`, 32: accumulator/result width. Must be ≥ 2·DATA_W; elaboration error otherwise.
- `AW`, $clog2(DEPTH): coefficient address width (derived).
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  AW  coefficient write index.
- `coef_wdata`  in  DATA_W  coefficient write data.
- `start`  in  1  request a new accumulation; sampled only when idle.
- `b_in`  in  DATA_W  scalar operand B, latched on accepted start.
- `count`  in  AW+1  number of terms; 0 or >DEPTH means DEPTH.
- `sgn`  in  1  1 = two's-complement operands/accumulation, 0 = unsigned; latched on start.
- `busy`  out  1  accumulation in progress.
- `done`  out  1  one-cycle pulse: `result`/`overflow` just updated.
- `result`  out  ACC_W  final sum, held until next completion.
- `overflow`  out  1  sum left the ACC_W range during the last run; held with `result`.

## Operation
- Reset: `busy`=0, `done`=0, `result`=0, `overflow`=0, FSM=IDLE, coefficient entry i = i+1 (legacy default table 1..DEPTH).
- FSM states: IDLE, RUN.
- IDLE: `start`=1 → latch `b_in`, `sgn`, effective length L; acc←0, idx←0, ovf←0; go RUN, `busy`←1.
- RUN: each cycle acc←acc+P, P = coef[idx]·B (2·DATA_W product, sign-extended if sgn else zero-extended to ACC_W); idx←idx+1.
- On the L-th term: `result`←acc+P, `overflow`←ovf|(this add overflows), `done`←1, `busy`←0, go IDLE.
- Overflow: unsigned = carry out of ACC_W; signed = both addends same sign, sum sign differs. Sticky within a run; result wraps modulo 2^ACC_W.
- Coefficient writes: applied in IDLE only; `coef_we` while `busy`=1 is dropped. Write with coef_addr ≥ DEPTH is dropped.
- `start` while `busy`=1 is ignored (no queuing). `start` and `coef_we` in the same IDLE cycle: write lands; the run uses the new value if idx reaches that address (write precedes first read).
- idx never wraps: L ≤ DEPTH.

## Timing
- Start accepted at edge k; `busy` high after edge k through edge k+L; MAC terms at edges k+1..k+L.
- `done` high for exactly the cycle after edge k+L; `result` valid from the same edge. Latency start→done = L cycles.
- A new `start` may be accepted in the `done` cycle (back-to-back, no bubble); that run's result overwrites at its own completion.
- `rst` asserted mid-RUN: immediate return to reset state (including coefficient table); partial sum discarded, no `done`.
- All outputs registered; no combinational path input→output.

## Test plan
- Reset defaults, B=1, count=8, sgn=0 → `done` 8 cycles after start, `result`=36 (0x00000024), `overflow`=0.
- Default coefficients, B=0xFFFF, count=8: sgn=0 → `result`=0x0023FFDC; sgn=1 → `result`=0xFFFFFFDC (−36), `overflow`=0 in both.
- Count=3, B=2 → `result`=12 after 3 cycles; count=0 and count=9 each behave as 8 (B=1 → 36).
- Write all 8 coefficients 0xFFFF, B=0xFFFF, sgn=0, count=8 → `result`=0xFFF00008, `overflow`=1; next run with B=0 → `result`=0, `overflow`=0.
- Start during busy and `coef_we` during busy → both ignored: result unchanged versus undisturbed run (36), table unchanged on readback run.
- `rst` pulsed 3 cycles into a run → `busy`/`done`/`result`/`overflow`=0 at once; subsequent B=1 run returns 36 (table restored).
